// File: rtl/seq_mul_16.sv
// Sequential shift-and-add multiplier: one partial-product step per clock, start/busy/done handshake.
// Optional build macro MUL_SIGNED_EN selects two's-complement operands via radix-2 Booth recoding.
module seq_mul_16 #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH:0]       r_p_hi;
   logic [WIDTH-1:0]     r_p_lo;
   logic [CW-1:0]        r_cnt;
   logic                 r_busy;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_product;

   logic                 w_add_en;
   logic                 w_sub;
   logic [WIDTH:0]       w_ext;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_p_hi_acc;
   logic [WIDTH:0]       w_p_hi_nxt;
   logic [WIDTH-1:0]     w_p_lo_nxt;
   logic                 w_last;

`ifdef MUL_SIGNED_EN
   logic                 r_q_m1;

   // Booth pair {P_lo[0], q_m1}: 01 adds, 10 subtracts, 00/11 just shift.
   assign w_add_en = r_p_lo[0] ^ r_q_m1;
   assign w_sub    = r_p_lo[0] & ~r_q_m1;
   assign w_ext    = {r_mcand[WIDTH-1], r_mcand};
`else
   assign w_add_en = r_p_lo[0];
   assign w_sub    = 1'b0;
   assign w_ext    = {1'b0, r_mcand};
`endif

   // Single adder; subtract is invert-and-carry-in.
   assign w_sum      = r_p_hi + (w_ext ^ {(WIDTH+1){w_sub}}) + {{WIDTH{1'b0}}, w_sub};
   assign w_p_hi_acc = w_add_en ? w_sum : r_p_hi;

`ifdef MUL_SIGNED_EN
   assign w_p_hi_nxt = {w_p_hi_acc[WIDTH], w_p_hi_acc[WIDTH:1]};
`else
   assign w_p_hi_nxt = {1'b0, w_p_hi_acc[WIDTH:1]};
`endif

   assign w_p_lo_nxt = {w_p_hi_acc[0], r_p_lo[WIDTH-1:1]};
   assign w_last     = (r_cnt == CW'(WIDTH - 1));

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_mcand   <= '0;
         r_p_hi    <= '0;
         r_p_lo    <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
`ifdef MUL_SIGNED_EN
         r_q_m1    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mcand <= multiplicand;
                  r_p_hi  <= '0;
                  r_p_lo  <= multiplier;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
`ifdef MUL_SIGNED_EN
                  r_q_m1  <= 1'b0;
`endif
               end
            end
            S_CALC: begin
               r_p_hi <= w_p_hi_nxt;
               r_p_lo <= w_p_lo_nxt;
               r_cnt  <= r_cnt + 1'b1;
`ifdef MUL_SIGNED_EN
               r_q_m1 <= r_p_lo[0];
`endif
               // Product is taken from the final step's result on the same edge DONE is entered.
               if (w_last) begin
                  r_product <= {w_p_hi_nxt[WIDTH-1:0], w_p_lo_nxt};
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_product;

endmodule

// File: tb/tb_seq_mul_16.sv
// Self-checking bench for seq_mul_16: scoreboard of expected products, latency and handshake checks.
// Build with +define+MUL_SIGNED_EN to exercise the signed Booth variant.
module tb_seq_mul_16;

   localparam int WIDTH = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   int n_checks = 0;
   int n_pass   = 0;

   logic [2*WIDTH-1:0]   exp_q[$];
   logic [2*WIDTH-1:0]   hold_val;

   seq_mul_16 #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MUL_SIGNED_EN
      logic signed [2*WIDTH-1:0] sa;
      logic signed [2*WIDTH-1:0] sb;
      sa = {{WIDTH{a[WIDTH-1]}}, a};
      sb = {{WIDTH{b[WIDTH-1]}}, b};
      return sa * sb;
`else
      logic [2*WIDTH-1:0] ua;
      logic [2*WIDTH-1:0] ub;
      ua = {{WIDTH{1'b0}}, a};
      ub = {{WIDTH{1'b0}}, b};
      return ua * ub;
`endif
   endfunction

   // Monitor: scores every done pulse and checks the product is held between pulses.
   always @(negedge clk) begin
      if (rst) begin
         hold_val = '0;
         exp_q.delete();
      end else if (done) begin
         if (exp_q.size() == 0) check("unexpected_done", 64'(done), 64'(0));
         else check("product", 64'(product), 64'(exp_q.pop_front()));
         hold_val = product;
      end else begin
         check("product_hold", 64'(product), 64'(hold_val));
      end
   end

   // Counts edges from the accepting edge until done is seen; bounded.
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int n;
      @(negedge clk);
      start = 1'b1; multiplicand = a; multiplier = b;
      @(posedge clk);
      exp_q.push_back(model(a, b));
      #1;
      start = 1'b0;
      multiplicand = WIDTH'($urandom);
      multiplier   = WIDTH'($urandom);
      check("busy_rise", 64'(busy), 64'(1));
      wait_done(n);
      check("latency", 64'(n), 64'(WIDTH));
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'(0));
      check("busy_fall", 64'(busy), 64'(0));
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_product", 64'(product), 64'(0));
      @(negedge clk); #2 rst = 1'b0;

      run_op(16'h0003, 16'h0005);
      run_op(16'hFFFF, 16'hFFFF);
      run_op(16'h0000, 16'h1234);

      // Starts pulsed during CALC and during DONE must be ignored.
      @(negedge clk);
      start = 1'b1; multiplicand = 16'h0010; multiplier = 16'h0010;
      @(posedge clk);
      exp_q.push_back(model(16'h0010, 16'h0010));
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      start = 1'b1; multiplicand = 16'h0002; multiplier = 16'h0002;
      @(negedge clk) start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("repulse_done_seen", 64'(done), 64'(1));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("repulse_busy_fall", 64'(busy), 64'(0));
      repeat (WIDTH + 4) @(posedge clk);
      #1 check("repulse_no_second_op", 64'(busy), 64'(0));

      // Asynchronous reset mid-CALC aborts the operation.
      @(negedge clk);
      start = 1'b1; multiplicand = 16'h1234; multiplier = 16'h5678;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_product", 64'(product), 64'(0));
      @(negedge clk); #2 rst = 1'b0;
      run_op(16'h0007, 16'h0009);

      // Start held high: an operation is accepted every WIDTH+2 edges.
      @(negedge clk);
      start = 1'b1; multiplicand = 16'h0100; multiplier = 16'h0100;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         exp_q.push_back(model(16'h0100, 16'h0100));
         #1 check("b2b_accept", 64'(busy), 64'(1));
         wait_done(n);
         check("b2b_latency", 64'(n), 64'(WIDTH));
         if (k == 2) start = 1'b0;
         @(posedge clk); #1;
         check("b2b_idle_gap", 64'(busy), 64'(0));
         check("b2b_done_low", 64'(done), 64'(0));
      end

`ifdef MUL_SIGNED_EN
      run_op(16'hFFFF, 16'h0002);
      run_op(16'h8000, 16'h8000);
      run_op(16'h8000, 16'h7FFF);
`else
      run_op(16'h8000, 16'h7FFF);
`endif
      for (int k = 0; k < 4; k++) run_op(WIDTH'($urandom), WIDTH'($urandom));

      repeat (3) @(posedge clk);
      #1 check("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
